// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of every handshake and bus signal around the
//                single-ported memory arbiter: the instruction-fetch
//                requester, the execute-stage load/store requester, the
//                execute stall and the memory-side request/acknowledge.
//
//  Modports    : slave  - the arbiter's view (i* inputs, o* outputs)
//                master - requesters, execute stage and memory wrapper
//
//  Signal summary
//    Fetch   : iFetchReq, iFetchAddr -> oFetchGnt, oFetchValid, oFetchData
//    Data    : iMemReq, iMemWrite, iMemAddr, iMemWData, iMemBe, iMemRdAddr
//              -> oMemGnt, oMemValid, oMemRData, oMemRdAddr
//    Execute : oStall
//    Memory  : oRamReq, oRamWe, oRamAddr, oRamWData, oRamBe
//              <- iRamAck, iRamRData
//    Status  : oBusErr (watchdog abort pulse)
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);

  // Instruction-fetch requester
  logic                    iFetchReq;
  logic [ADDR_W-1:0]       iFetchAddr;
  logic                    oFetchGnt;
  logic                    oFetchValid;
  logic [DATA_W-1:0]       oFetchData;

  // Execute-stage load/store requester
  logic                    iMemReq;
  logic                    iMemWrite;
  logic [ADDR_W-1:0]       iMemAddr;
  logic [DATA_W-1:0]       iMemWData;
  logic [DATA_W/8-1:0]     iMemBe;
  logic [REG_ADDR_W-1:0]   iMemRdAddr;
  logic                    oMemGnt;
  logic                    oMemValid;
  logic [DATA_W-1:0]       oMemRData;
  logic [REG_ADDR_W-1:0]   oMemRdAddr;

  // Execute freeze
  logic                    oStall;

  // Memory side
  logic                    oRamReq;
  logic                    oRamWe;
  logic [ADDR_W-1:0]       oRamAddr;
  logic [DATA_W-1:0]       oRamWData;
  logic [DATA_W/8-1:0]     oRamBe;
  logic                    iRamAck;
  logic [DATA_W-1:0]       iRamRData;

  // Watchdog abort
  logic                    oBusErr;

  modport slave (
    input  iFetchReq, iFetchAddr,
    output oFetchGnt, oFetchValid, oFetchData,
    input  iMemReq, iMemWrite, iMemAddr, iMemWData, iMemBe, iMemRdAddr,
    output oMemGnt, oMemValid, oMemRData, oMemRdAddr,
    output oStall,
    output oRamReq, oRamWe, oRamAddr, oRamWData, oRamBe,
    input  iRamAck, iRamRData,
    output oBusErr
  );

  modport master (
    output iFetchReq, iFetchAddr,
    input  oFetchGnt, oFetchValid, oFetchData,
    output iMemReq, iMemWrite, iMemAddr, iMemWData, iMemBe, iMemRdAddr,
    input  oMemGnt, oMemValid, oMemRData, oMemRdAddr,
    input  oStall,
    input  oRamReq, oRamWe, oRamAddr, oRamWData, oRamBe,
    output iRamAck, iRamRData,
    input  oBusErr
  );

endinterface : mem_port_arbiter_if

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory bus between instruction
//                fetch and execute-stage loads/stores. Each access is
//                granted from IDLE, held stable on the memory-side outputs
//                until acknowledged, and its read data returned to the
//                requester that owned it. Data accesses normally win; after
//                MAX_DATA_BURST data grants issued while fetch was waiting,
//                fetch is given the next slot.
//
//  Ports       : iClk  - clock, rising edge
//                iRst  - asynchronous active-high reset
//                bus   - mem_port_arbiter_if.slave (requesters, stall,
//                        memory side, bus error)
//
//  Options     : MEM_ARB_TIMEOUT_EN - when defined, a watchdog aborts an
//                access after TIMEOUT_CYCLES busy cycles without iRamAck,
//                completing it with zero data and an oBusErr pulse. When
//                undefined the FSM waits for iRamAck indefinitely and
//                oBusErr is tied low.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int REG_ADDR_W     = 5,
  parameter int MAX_DATA_BURST = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  wire logic         iClk,
  input  wire logic         iRst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W    = DATA_W / 8;
  localparam int BURST_W = $clog2(MAX_DATA_BURST + 1);

  localparam logic [BURST_W-1:0] c_BURST_MAX = BURST_W'(MAX_DATA_BURST);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_BUSY_FETCH = 2'd1;
  localparam logic [1:0] c_BUSY_DATA  = 2'd2;

  // --------------------------------------------------------------------------
  // State and registered outputs
  // --------------------------------------------------------------------------
  logic [1:0]            r_state;
  logic [BURST_W-1:0]    r_burstCnt;

  logic                  r_ramReq;
  logic                  r_ramWe;
  logic [ADDR_W-1:0]     r_ramAddr;
  logic [DATA_W-1:0]     r_ramWData;
  logic [BE_W-1:0]       r_ramBe;
  logic [REG_ADDR_W-1:0] r_rdAddr;

  logic                  r_fetchGnt;
  logic                  r_fetchValid;
  logic [DATA_W-1:0]     r_fetchData;

  logic                  r_memGnt;
  logic                  r_memValid;
  logic [DATA_W-1:0]     r_memRData;
  logic [REG_ADDR_W-1:0] r_memRdAddr;

  // --------------------------------------------------------------------------
  // Arbitration and completion
  // --------------------------------------------------------------------------
  logic                  w_idle;
  logic                  w_busy;
  logic                  w_fetchPriority;
  logic                  w_grantData;
  logic                  w_grantFetch;
  logic                  w_timeout;
  logic                  w_done;
  logic [DATA_W-1:0]     w_doneData;

  assign w_idle = (r_state == c_IDLE);
  assign w_busy = (r_state == c_BUSY_FETCH) | (r_state == c_BUSY_DATA);

  // Fetch only overrides data once it has watched a full burst go by.
  assign w_fetchPriority = bus.iFetchReq & (r_burstCnt == c_BURST_MAX);
  assign w_grantData     = w_idle & bus.iMemReq & ~w_fetchPriority;
  assign w_grantFetch    = w_idle & bus.iFetchReq & ~w_grantData;

  // An access ends on an ack or a watchdog abort; an abort returns zero data.
  assign w_done     = w_busy & (bus.iRamAck | w_timeout);
  assign w_doneData = bus.iRamAck ? bus.iRamRData : '0;

  // --------------------------------------------------------------------------
  // Main FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state      <= c_IDLE;
      r_burstCnt   <= '0;
      r_ramReq     <= 1'b0;
      r_ramWe      <= 1'b0;
      r_ramAddr    <= '0;
      r_ramWData   <= '0;
      r_ramBe      <= '0;
      r_rdAddr     <= '0;
      r_fetchGnt   <= 1'b0;
      r_fetchValid <= 1'b0;
      r_fetchData  <= '0;
      r_memGnt     <= 1'b0;
      r_memValid   <= 1'b0;
      r_memRData   <= '0;
      r_memRdAddr  <= '0;
    end else begin
      // Grant and completion strobes are single-cycle pulses.
      r_fetchGnt   <= 1'b0;
      r_memGnt     <= 1'b0;
      r_fetchValid <= 1'b0;
      r_memValid   <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (w_grantData) begin
            r_state    <= c_BUSY_DATA;
            r_memGnt   <= 1'b1;
            r_ramReq   <= 1'b1;
            r_ramWe    <= bus.iMemWrite;
            r_ramAddr  <= bus.iMemAddr;
            r_ramWData <= bus.iMemWData;
            r_ramBe    <= bus.iMemBe;
            r_rdAddr   <= bus.iMemRdAddr;
            // Only data grants that made fetch wait count toward the burst.
            if (bus.iFetchReq && (r_burstCnt != c_BURST_MAX)) begin
              r_burstCnt <= r_burstCnt + 1'b1;
            end
          end else if (w_grantFetch) begin
            r_state    <= c_BUSY_FETCH;
            r_fetchGnt <= 1'b1;
            r_ramReq   <= 1'b1;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= bus.iFetchAddr;
            r_ramWData <= '0;
            r_ramBe    <= '1;
            r_burstCnt <= '0;
          end
        end

        c_BUSY_FETCH: begin
          if (w_done) begin
            r_state      <= c_IDLE;
            r_ramReq     <= 1'b0;
            r_fetchValid <= 1'b1;
            r_fetchData  <= w_doneData;
          end
        end

        c_BUSY_DATA: begin
          if (w_done) begin
            r_state    <= c_IDLE;
            r_ramReq   <= 1'b0;
            r_memValid <= 1'b1;
            // A store completes with no result and no destination register.
            if (r_ramWe) begin
              r_memRData  <= '0;
              r_memRdAddr <= '0;
            end else begin
              r_memRData  <= w_doneData;
              r_memRdAddr <= r_rdAddr;
            end
          end
        end

        default: begin
          r_state  <= c_IDLE;
          r_ramReq <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Ack watchdog
  // --------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WDOG_W-1:0] c_WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_busErr;

  // r_wdog reads k-1 in the k-th busy cycle, so the abort fires at the end
  // of the TIMEOUT_CYCLES-th cycle without an ack.
  assign w_timeout = w_busy & ~bus.iRamAck & (r_wdog == c_WDOG_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_wdog   <= '0;
      r_busErr <= 1'b0;
    end else begin
      r_busErr <= w_timeout;
      if (w_grantData || w_grantFetch) begin
        r_wdog <= '0;
      end else if (w_busy && (r_wdog != c_WDOG_LAST)) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end
  end

  assign bus.oBusErr = r_busErr;
`else
  assign w_timeout   = 1'b0;
  assign bus.oBusErr = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.oFetchGnt   = r_fetchGnt;
  assign bus.oFetchValid = r_fetchValid;
  assign bus.oFetchData  = r_fetchData;

  assign bus.oMemGnt     = r_memGnt;
  assign bus.oMemValid   = r_memValid;
  assign bus.oMemRData   = r_memRData;
  assign bus.oMemRdAddr  = r_memRdAddr;

  assign bus.oRamReq     = r_ramReq;
  assign bus.oRamWe      = r_ramWe;
  assign bus.oRamAddr    = r_ramAddr;
  assign bus.oRamWData   = r_ramWData;
  assign bus.oRamBe      = r_ramBe;

  // Execute freezes for the whole data access, and also in the cycle a data
  // request is still waiting for its grant.
  assign bus.oStall = (r_state == c_BUSY_DATA) | (bus.iMemReq & ~r_memGnt);

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Directed tasks
//                cover reset, a zero-wait load, a store with wait states,
//                held contention, reset in the middle of an access and the
//                ack watchdog (or its absence). A randomized task runs
//                transactions against a transaction-level model of the
//                arbitration rules, burst counter and held read data.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_BURST  = 4;
  localparam int TMO        = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model state
  int                    m_burst = 0;
  logic [DATA_W-1:0]     m_fdata = '0;
  logic [DATA_W-1:0]     m_mdata = '0;
  logic [REG_ADDR_W-1:0] m_mrd   = '0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .REG_ADDR_W     (REG_ADDR_W),
    .MAX_DATA_BURST (MAX_BURST)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TMO)
`endif
  ) dut (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.iFetchReq  = 1'b0;
    bus.iFetchAddr = '0;
    bus.iMemReq    = 1'b0;
    bus.iMemWrite  = 1'b0;
    bus.iMemAddr   = '0;
    bus.iMemWData  = '0;
    bus.iMemBe     = '0;
    bus.iMemRdAddr = '0;
    bus.iRamAck    = 1'b0;
    bus.iRamRData  = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    m_burst = 0;
    m_fdata = '0;
    m_mdata = '0;
    m_mrd   = '0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    tick();
    n_checks++;
    if ({bus.oFetchGnt, bus.oFetchValid, bus.oFetchData, bus.oMemGnt, bus.oMemValid,
         bus.oMemRData, bus.oMemRdAddr, bus.oStall, bus.oRamReq, bus.oRamWe, bus.oRamAddr,
         bus.oRamWData, bus.oRamBe, bus.oBusErr} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got ramReq=%b ramAddr=%h fetchData=%h memRData=%h required all 0",
               bus.oRamReq, bus.oRamAddr, bus.oFetchData, bus.oMemRData);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({bus.oRamReq, bus.oStall, bus.oFetchGnt, bus.oMemGnt} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release got ramReq=%b stall=%b fgnt=%b mgnt=%b required 0",
               bus.oRamReq, bus.oStall, bus.oFetchGnt, bus.oMemGnt);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_load_zero_wait;
    do_reset();
    bus.iMemReq    = 1'b1;
    bus.iMemWrite  = 1'b0;
    bus.iMemAddr   = 32'h0000_0100;
    bus.iMemRdAddr = 5'd5;
    #1;
    n_checks++;
    if (bus.oStall !== 1'b1 || bus.oMemGnt !== 1'b0) begin
      n_fail++;
      $display("FAIL load_cycle0 got stall=%b gnt=%b required stall=1 gnt=0", bus.oStall, bus.oMemGnt);
    end
    tick();
    n_checks++;
    if (bus.oMemGnt !== 1'b1 || bus.oRamReq !== 1'b1 || bus.oRamWe !== 1'b0 ||
        bus.oRamAddr !== 32'h100 || bus.oStall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_cycle1 got gnt=%b req=%b we=%b addr=%h stall=%b required 1 1 0 100 1",
               bus.oMemGnt, bus.oRamReq, bus.oRamWe, bus.oRamAddr, bus.oStall);
    end
    bus.iMemReq   = 1'b0;
    bus.iRamAck   = 1'b1;
    bus.iRamRData = 32'hDEAD_BEEF;
    tick();
    bus.iRamAck = 1'b0;
    #1;
    n_checks++;
    if (bus.oMemValid !== 1'b1 || bus.oMemRData !== 32'hDEAD_BEEF || bus.oMemRdAddr !== 5'd5 ||
        bus.oStall !== 1'b0 || bus.oRamReq !== 1'b0) begin
      n_fail++;
      $display("FAIL load_cycle2 got valid=%b rdata=%h rd=%0d stall=%b req=%b required 1 deadbeef 5 0 0",
               bus.oMemValid, bus.oMemRData, bus.oMemRdAddr, bus.oStall, bus.oRamReq);
    end
    tick();
    n_checks++;
    if (bus.oMemValid !== 1'b0 || bus.oMemRData !== 32'hDEAD_BEEF || bus.oMemRdAddr !== 5'd5) begin
      n_fail++;
      $display("FAIL load_hold got valid=%b rdata=%h rd=%0d required 0 deadbeef 5",
               bus.oMemValid, bus.oMemRData, bus.oMemRdAddr);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_store_wait3;
    do_reset();
    bus.iMemReq    = 1'b1;
    bus.iMemWrite  = 1'b1;
    bus.iMemAddr   = 32'h0000_0200;
    bus.iMemWData  = 32'h1234_5678;
    bus.iMemBe     = 4'hF;
    bus.iMemRdAddr = 5'd9;
    tick();
    bus.iMemReq = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      bus.iRamAck   = (c == 4);
      bus.iRamRData = 32'hCAFE_0000 + c;
      #1;
      n_checks++;
      if (bus.oRamReq !== 1'b1 || bus.oRamWe !== 1'b1 || bus.oRamAddr !== 32'h200 ||
          bus.oRamWData !== 32'h1234_5678 || bus.oRamBe !== 4'hF || bus.oMemValid !== 1'b0 ||
          bus.oStall !== 1'b1) begin
        n_fail++;
        $display("FAIL store_hold c=%0d got req=%b we=%b addr=%h wd=%h be=%h valid=%b stall=%b required 1 1 200 12345678 f 0 1",
                 c, bus.oRamReq, bus.oRamWe, bus.oRamAddr, bus.oRamWData, bus.oRamBe,
                 bus.oMemValid, bus.oStall);
      end
      tick();
    end
    bus.iRamAck = 1'b0;
    n_checks++;
    if (bus.oMemValid !== 1'b1 || bus.oMemRData !== 32'h0 || bus.oMemRdAddr !== 5'd0 ||
        bus.oRamReq !== 1'b0) begin
      n_fail++;
      $display("FAIL store_done got valid=%b rdata=%h rd=%0d req=%b required 1 0 0 0",
               bus.oMemValid, bus.oMemRData, bus.oMemRdAddr, bus.oRamReq);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_contention;
    bit exp_data;
    do_reset();
    bus.iFetchReq  = 1'b1;
    bus.iFetchAddr = 32'h0000_4000;
    bus.iMemReq    = 1'b1;
    bus.iMemWrite  = 1'b0;
    bus.iMemAddr   = 32'h0000_0300;
    bus.iMemRdAddr = 5'd7;
    for (int g = 0; g < 10; g++) begin
      // With fetch always waiting: MAX_BURST data grants, then one fetch.
      exp_data = (g % (MAX_BURST + 1)) != MAX_BURST;
      tick();
      n_checks++;
      if (bus.oMemGnt !== exp_data || bus.oFetchGnt !== !exp_data) begin
        n_fail++;
        $display("FAIL contention_grant g=%0d got mem=%b fetch=%b required mem=%b fetch=%b",
                 g, bus.oMemGnt, bus.oFetchGnt, exp_data, !exp_data);
      end
      bus.iRamAck   = 1'b1;
      bus.iRamRData = 32'h5000 + g;
      tick();
      bus.iRamAck = 1'b0;
    end
    clear_inputs();
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid_access;
    do_reset();
    bus.iFetchReq  = 1'b1;
    bus.iFetchAddr = 32'h0000_8000;
    tick();
    n_checks++;
    if (bus.oFetchGnt !== 1'b1 || bus.oRamReq !== 1'b1 || bus.oRamAddr !== 32'h8000) begin
      n_fail++;
      $display("FAIL midrst_grant got gnt=%b req=%b addr=%h required 1 1 8000",
               bus.oFetchGnt, bus.oRamReq, bus.oRamAddr);
    end
    bus.iFetchReq = 1'b0;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.oFetchGnt, bus.oFetchValid, bus.oFetchData, bus.oMemGnt, bus.oMemValid,
         bus.oMemRData, bus.oMemRdAddr, bus.oStall, bus.oRamReq, bus.oRamWe, bus.oRamAddr,
         bus.oRamWData, bus.oRamBe, bus.oBusErr} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async got req=%b addr=%h be=%h required all 0",
               bus.oRamReq, bus.oRamAddr, bus.oRamBe);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.iRamAck   = 1'b1;
    bus.iRamRData = 32'hBAD0_0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.oFetchValid !== 1'b0 || bus.oRamReq !== 1'b0 || bus.oFetchData !== 32'h0) begin
        n_fail++;
        $display("FAIL midrst_stray_ack k=%0d got valid=%b req=%b data=%h required 0 0 0",
                 k, bus.oFetchValid, bus.oRamReq, bus.oFetchData);
      end
    end
    bus.iRamAck = 1'b0;
  endtask

  // --------------------------------------------------------------------------
`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset();
    bus.iFetchReq  = 1'b1;
    bus.iFetchAddr = 32'h0000_A000;
    bus.iRamRData  = 32'hFFFF_FFFF;
    tick();
    bus.iFetchReq = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      n_checks++;
      if (bus.oRamReq !== 1'b1 || bus.oBusErr !== 1'b0 || bus.oFetchValid !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait k=%0d got req=%b err=%b valid=%b required 1 0 0",
                 k, bus.oRamReq, bus.oBusErr, bus.oFetchValid);
      end
      tick();
    end
    n_checks++;
    if (bus.oBusErr !== 1'b1 || bus.oFetchValid !== 1'b1 || bus.oFetchData !== 32'h0 ||
        bus.oRamReq !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_abort got err=%b valid=%b data=%h req=%b required 1 1 0 0",
               bus.oBusErr, bus.oFetchValid, bus.oFetchData, bus.oRamReq);
    end
    bus.iMemReq    = 1'b1;
    bus.iMemWrite  = 1'b0;
    bus.iMemAddr   = 32'h0000_0040;
    bus.iMemRdAddr = 5'd3;
    tick();
    n_checks++;
    if (bus.oMemGnt !== 1'b1 || bus.oBusErr !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_regrant got gnt=%b err=%b required 1 0", bus.oMemGnt, bus.oBusErr);
    end
    bus.iMemReq = 1'b0;
    bus.iRamAck = 1'b1;
    tick();
    bus.iRamAck = 1'b0;
    tick();
  endtask
`else
  task automatic test_no_timeout;
    do_reset();
    bus.iFetchReq  = 1'b1;
    bus.iFetchAddr = 32'h0000_A000;
    tick();
    bus.iFetchReq = 1'b0;
    for (int k = 1; k <= TMO + 4; k++) begin
      n_checks++;
      if (bus.oRamReq !== 1'b1 || bus.oBusErr !== 1'b0 || bus.oFetchValid !== 1'b0) begin
        n_fail++;
        $display("FAIL nowdog_wait k=%0d got req=%b err=%b valid=%b required 1 0 0",
                 k, bus.oRamReq, bus.oBusErr, bus.oFetchValid);
      end
      tick();
    end
    bus.iRamAck   = 1'b1;
    bus.iRamRData = 32'h0BAD_F00D;
    tick();
    bus.iRamAck = 1'b0;
    n_checks++;
    if (bus.oFetchValid !== 1'b1 || bus.oFetchData !== 32'h0BAD_F00D || bus.oBusErr !== 1'b0) begin
      n_fail++;
      $display("FAIL nowdog_done got valid=%b data=%h err=%b required 1 0badf00d 0",
               bus.oFetchValid, bus.oFetchData, bus.oBusErr);
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  task automatic test_random;
    bit                    f_pend = 1'b0;
    bit                    d_pend = 1'b0;
    bit                    d_wr   = 1'b0;
    bit                    win_data;
    bit                    exp_fv = 1'b0;
    bit                    exp_mv = 1'b0;
    logic [ADDR_W-1:0]     f_addr  = '0;
    logic [ADDR_W-1:0]     d_addr  = '0;
    logic [ADDR_W-1:0]     exp_addr;
    logic [DATA_W-1:0]     d_wdata = '0;
    logic [DATA_W-1:0]     rdata   = '0;
    logic [3:0]            d_be    = '0;
    logic [REG_ADDR_W-1:0] d_rd    = '0;
    int                    waits;

    do_reset();
    for (int t = 0; t < 80; t++) begin
      // IDLE cycle: the previous access's completion is visible here.
      n_checks++;
      if (bus.oFetchValid !== exp_fv || bus.oMemValid !== exp_mv) begin
        n_fail++;
        $display("FAIL rnd_valid t=%0d got fv=%b mv=%b required fv=%b mv=%b",
                 t, bus.oFetchValid, bus.oMemValid, exp_fv, exp_mv);
      end
      n_checks++;
      if (bus.oFetchData !== m_fdata || bus.oMemRData !== m_mdata || bus.oMemRdAddr !== m_mrd) begin
        n_fail++;
        $display("FAIL rnd_data t=%0d got f=%h m=%h rd=%0d required f=%h m=%h rd=%0d",
                 t, bus.oFetchData, bus.oMemRData, bus.oMemRdAddr, m_fdata, m_mdata, m_mrd);
      end
      n_checks++;
      if (bus.oRamReq !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_idle_req t=%0d got %b required 0", t, bus.oRamReq);
      end

      if (!f_pend && $urandom_range(0, 2) != 0) begin
        f_pend = 1'b1;
        f_addr = $urandom;
      end
      if (!d_pend && $urandom_range(0, 2) != 0) begin
        d_pend  = 1'b1;
        d_wr    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
        d_rd    = 5'($urandom_range(0, 31));
      end
      bus.iFetchReq  = f_pend;
      bus.iFetchAddr = f_addr;
      bus.iMemReq    = d_pend;
      bus.iMemWrite  = d_wr;
      bus.iMemAddr   = d_addr;
      bus.iMemWData  = d_wdata;
      bus.iMemBe     = d_be;
      bus.iMemRdAddr = d_rd;
      bus.iRamAck    = 1'($urandom_range(0, 1));
      bus.iRamRData  = $urandom;
      #1;
      n_checks++;
      if (bus.oStall !== d_pend) begin
        n_fail++;
        $display("FAIL rnd_stall_idle t=%0d got %b required %b", t, bus.oStall, d_pend);
      end

      exp_fv = 1'b0;
      exp_mv = 1'b0;
      if (!f_pend && !d_pend) begin
        tick();
        continue;
      end

      // Model: data wins unless fetch has waited through a full burst.
      win_data = d_pend && !(f_pend && m_burst == MAX_BURST);
      if (!win_data)   m_burst = 0;
      else if (f_pend) m_burst = (m_burst >= MAX_BURST) ? MAX_BURST : m_burst + 1;
      exp_addr = win_data ? d_addr : f_addr;

      tick();
      n_checks++;
      if (bus.oMemGnt !== win_data || bus.oFetchGnt !== !win_data) begin
        n_fail++;
        $display("FAIL rnd_grant t=%0d got mem=%b fetch=%b required mem=%b burst=%0d",
                 t, bus.oMemGnt, bus.oFetchGnt, win_data, m_burst);
      end
      n_checks++;
      if (bus.oRamWe !== (win_data & d_wr) ||
          (win_data && d_wr && {bus.oRamWData, bus.oRamBe} !== {d_wdata, d_be})) begin
        n_fail++;
        $display("FAIL rnd_payload t=%0d got we=%b wd=%h be=%h required we=%b wd=%h be=%h",
                 t, bus.oRamWe, bus.oRamWData, bus.oRamBe, win_data & d_wr, d_wdata, d_be);
      end

      if (win_data) d_pend = 1'b0;
      else          f_pend = 1'b0;
      bus.iMemReq   = d_pend;
      bus.iFetchReq = f_pend;

      waits = $urandom_range(0, 3);
      for (int w = 0; w <= waits; w++) begin
        bus.iRamAck   = (w == waits);
        rdata         = $urandom;
        bus.iRamRData = rdata;
        #1;
        n_checks++;
        if (bus.oRamReq !== 1'b1 || bus.oRamAddr !== exp_addr ||
            bus.oFetchValid !== 1'b0 || bus.oMemValid !== 1'b0) begin
          n_fail++;
          $display("FAIL rnd_busy t=%0d w=%0d got req=%b addr=%h fv=%b mv=%b required 1 %h 0 0",
                   t, w, bus.oRamReq, bus.oRamAddr, bus.oFetchValid, bus.oMemValid, exp_addr);
        end
        n_checks++;
        if (bus.oStall !== (win_data | d_pend)) begin
          n_fail++;
          $display("FAIL rnd_stall_busy t=%0d w=%0d got %b required %b",
                   t, w, bus.oStall, win_data | d_pend);
        end
        tick();
      end
      bus.iRamAck = 1'b0;

      if (win_data) begin
        exp_mv  = 1'b1;
        m_mdata = d_wr ? '0 : rdata;
        m_mrd   = d_wr ? '0 : d_rd;
      end else begin
        exp_fv  = 1'b1;
        m_fdata = rdata;
      end
    end

    n_checks++;
    if (bus.oFetchValid !== exp_fv || bus.oMemValid !== exp_mv || bus.oFetchData !== m_fdata ||
        bus.oMemRData !== m_mdata || bus.oMemRdAddr !== m_mrd) begin
      n_fail++;
      $display("FAIL rnd_final got fv=%b mv=%b f=%h m=%h required fv=%b mv=%b f=%h m=%h",
               bus.oFetchValid, bus.oMemValid, bus.oFetchData, bus.oMemRData,
               exp_fv, exp_mv, m_fdata, m_mdata);
    end
    clear_inputs();
  endtask

  // --------------------------------------------------------------------------
  initial begin
    clear_inputs();
    test_reset();
    test_load_zero_wait();
    test_store_wait3();
    test_contention();
    test_reset_mid_access();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL tb_time_limit got checks=%0d required completion", n_checks);
    $fatal(1, "simulation time limit");
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-ported memory bus between the instruction-fetch requester and the ALU load/store requester (the `memOp` addr/read/rdAddr bundle produced by the execute stage). It sequences each access through a small FSM, holds the memory request stable until the memory acknowledges it, and returns read data to the winner. It drives the stall that freezes execute while a data access is pending. It sits between the execute stage and the memory wrapper.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte enables are `DATA_W/8`
- `REG_ADDR_W`, 5, destination register address width
- `MAX_DATA_BURST`, 4, consecutive data grants allowed while fetch waits
- `TIMEOUT_CYCLES`, 16, ack watchdog limit; used only with `MEM_ARB_TIMEOUT_EN`
- Clock and reset: one clock; reset is asynchronous and active-high.
- `iClk` in 1: clock, rising edge.
- `iRst` in 1: asynchronous, active-high reset.
- `iFetchReq` in 1: fetch request, held until granted.
- `iFetchAddr` in ADDR_W: fetch address.
- `oFetchGnt` out 1: one-cycle pulse; the fetch request was accepted.
- `oFetchValid` out 1: one-cycle pulse; `oFetchData` is valid.
- `oFetchData` out DATA_W: fetch read data.
- `iMemReq` in 1: data request, held until granted.
- `iMemWrite` in 1: 1 = store, 0 = load.
- `iMemAddr` in ADDR_W, `iMemWData` in DATA_W, `iMemBe` in DATA_W/8: store/load payload.
- `iMemRdAddr` in REG_ADDR_W: load destination register.
- `oMemGnt` out 1, `oMemValid` out 1: data grant and completion pulses.
- `oMemRData` out DATA_W, `oMemRdAddr` out REG_ADDR_W: load result and its destination register.
- `oStall` out 1: freeze execute.
- `oRamReq` out 1, `oRamWe` out 1, `oRamAddr` out ADDR_W, `oRamWData` out DATA_W, `oRamBe` out DATA_W/8: memory-side request.
- `iRamAck` in 1, `iRamRData` in DATA_W: memory acknowledge, with read data valid in the same cycle.
- `oBusErr` out 1: one-cycle pulse on a watchdog abort.

## Operation
- **FSM states:** IDLE, BUSY_FETCH, BUSY_DATA.
- **IDLE arbitration:**
  - Data wins over fetch.
  - Exception: fetch wins if `iFetchReq` is high and `burstCnt == MAX_DATA_BURST`.
- **On a grant edge:**
  - Latch the winner's payload onto the `oRam*` outputs and set `oRamReq=1`.
  - Pulse that requester's `Gnt`.
  - Move to the matching BUSY state.
- **Burst counter (`burstCnt`):**
  - Increments on each data grant issued while `iFetchReq` is high.
  - Saturates at `MAX_DATA_BURST`.
  - Clears on every fetch grant.
- **BUSY states:**
  - All `oRam*` outputs are held stable.
  - When `iRamAck` is sampled high: return to IDLE, drop `oRamReq`, and pulse the owner's `Valid`.
  - Fetch completion: `oFetchData` = `iRamRData`.
  - Load completion: `oMemRData` = `iRamRData`, `oMemRdAddr` = latched rdAddr.
  - Store completion: `oMemValid` pulses with `oMemRData=0` and `oMemRdAddr=0`.
- **Ignored inputs:**
  - `iRamAck` is ignored in IDLE.
  - Requests are ignored in BUSY states.
- **Requester rule:** after seeing `Gnt`, a requester deasserts or presents its next request before the next edge.
- **Stall:** `oStall` = (state==BUSY_DATA) | (`iMemReq` & ~`oMemGnt`). This is combinational.
- **Data hold:** `oFetchData`, `oMemRData` and `oMemRdAddr` hold their values between Valid pulses.

## Timing
- **Reset:** `iRst` asserted at any time, including mid-transaction, forces:
  - state IDLE and `burstCnt=0`;
  - every output to 0.
  - The outstanding memory access is abandoned, and a late `iRamAck` is ignored.
- **Minimum access:**
  - Request sampled at edge 0.
  - `Gnt` and `oRamReq` are high in cycle 1.
  - `iRamAck` is high in cycle 1 and sampled at edge 1.
  - `Valid` pulses in cycle 2.
- **Throughput:** peak is one transaction per 2 cycles. The next grant can occur at edge 2.
- **Wait states:** each cycle without `iRamAck` adds one cycle of latency.
- **Simultaneous requests in IDLE:** data is granted unless the burst limit is reached.
- **Register boundaries:** all outputs except `oStall` are registered.

## Configuration
- **`MEM_ARB_TIMEOUT_EN` defined:**
  - A watchdog counts cycles spent in a BUSY state.
  - After `TIMEOUT_CYCLES` cycles without `iRamAck`: return to IDLE, drop `oRamReq`, and pulse `oBusErr` together with the owner's `Valid`. Data is 0.
  - The watchdog clears on every grant.
- **`MEM_ARB_TIMEOUT_EN` undefined:**
  - The FSM waits for `iRamAck` indefinitely.
  - `oBusErr` is tied to 0.

## Test plan
- **Load, zero wait:** `iMemReq=1`, `iMemWrite=0`, `iMemAddr=0x100`, `iMemRdAddr=5`, ack in cycle 1 with rdata 0xDEADBEEF. Expect:
  - `oMemGnt` in cycle 1;
  - `oMemValid` in cycle 2 with `oMemRData=0xDEADBEEF` and `oMemRdAddr=5`;
  - `oStall` high in cycles 0-1.
- **Store, 3 wait states:** `iMemWrite=1`, addr 0x200, data 0x12345678, be 0xF. Expect:
  - `oRam*` stable for 4 cycles with `oRamWe=1`;
  - `oMemValid` one cycle after the ack, with `oMemRData=0`.
- **Contention:** both requests held continuously. Expect data grants 4 times, then 1 fetch grant, then data again, with `burstCnt` back to 0.
- **Reset mid-access:** `iRst` pulsed while in BUSY_FETCH with no ack, then ack asserted later. Expect:
  - all outputs 0 immediately;
  - no `oFetchValid`;
  - the stray ack ignored.
- **Timeout (macro defined, `TIMEOUT_CYCLES=16`):** fetch granted, no ack ever. Expect `oBusErr` and `oFetchValid` pulsed together, `oFetchData=0`, and the FSM back in IDLE, able to grant on the next edge.
